instr_fetch: RTL and testbench

//  Fetch stage between the PC logic and the instruction ROM. It drives the byte address and the
//  CS strobe into the ROM. It captures the returned 32-bit word and presents {instr, pc} to decode

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/instr_fetch.sv | 113 +++++++++++
 tb/tb_instr_fetch.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// reset/step defaults and a word-alignment helper.
package fetch_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [1:0]  ST_ADDR          = 2'd0;
  localparam logic [1:0]  ST_STROBE        = 2'd1;
  localparam logic [1:0]  ST_HOLD          = 2'd2;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_016c;
  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

  typedef enum logic [1:0] {
    S_ADDR   = ST_ADDR,
    S_STROBE = ST_STROBE,
    S_HOLD   = ST_HOLD
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: strobes the instruction ROM, captures the returned word and
// hands {instr, pc} to decode over valid/ready; execute redirects flush it.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  output logic [31:0]        rom_addr,
  output logic               rom_cs,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir_data,
  output logic [31:0]        ir_pc,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               misalign_fault,
  output logic [31:0]        fetch_count
);

  fetch_state_e       state, state_n;
  logic [31:0]        pc, pc_n;
  logic [31:0]        rom_addr_n;
  logic               rom_cs_n;
  logic               ir_valid_n;
  logic [INSTR_W-1:0] ir_data_n;
  logic [31:0]        ir_pc_n;
  logic               fault_n;
  logic [31:0]        count_n;
  // Set on the first edge after reset release, so the first ROM strobe
  // cannot rise before the second edge.
  logic               armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_ADDR;
      armed          <= 1'b0;
      pc             <= RESET_PC;
      rom_addr       <= RESET_PC;
      rom_cs         <= 1'b0;
      ir_valid       <= 1'b0;
      ir_data        <= '0;
      ir_pc          <= '0;
      misalign_fault <= 1'b0;
      fetch_count    <= '0;
    end else begin
      state          <= state_n;
      armed          <= 1'b1;
      pc             <= pc_n;
      rom_addr       <= rom_addr_n;
      rom_cs         <= rom_cs_n;
      ir_valid       <= ir_valid_n;
      ir_data        <= ir_data_n;
      ir_pc          <= ir_pc_n;
      misalign_fault <= fault_n;
      fetch_count    <= count_n;
    end
  end

  // rom_addr is reloaded on every entry to ADDR, so it is stable for the
  // whole ADDR/STROBE window; rom_cs is high only while in STROBE.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    rom_addr_n = rom_addr;
    rom_cs_n   = 1'b0;
    ir_valid_n = ir_valid;
    ir_data_n  = ir_data;
    ir_pc_n    = ir_pc;
    fault_n    = misalign_fault;
    count_n    = fetch_count;

    if (redirect_valid) begin
      state_n    = S_ADDR;
      pc_n       = align_word(redirect_pc);
      rom_addr_n = align_word(redirect_pc);
      ir_valid_n = 1'b0;
      if (redirect_pc[1:0] != 2'b00) fault_n = 1'b1;
    end else begin
      case (state)
        S_ADDR: begin
          if (armed) begin
            state_n  = S_STROBE;
            rom_cs_n = 1'b1;
          end
        end
        S_STROBE: begin
          ir_data_n  = rom_data;
          ir_pc_n    = pc;
          ir_valid_n = 1'b1;
          pc_n       = pc + PC_STEP;
          state_n    = S_HOLD;
        end
        S_HOLD: begin
          if (ir_ready) begin
            ir_valid_n = 1'b0;
            count_n    = fetch_count + 32'd1;
            rom_addr_n = pc;
            state_n    = S_ADDR;
          end
        end
        default: begin
          state_n    = S_ADDR;
          rom_addr_n = pc;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: behavioural ROM, scoreboard of expected
// {pc, data} pairs and immediate-assertion checks at each sampling point.
module tb_instr_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rom_addr;
  logic        rom_cs;
  logic [31:0] rom_data = '0;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic [31:0] ir_data;
  logic [31:0] ir_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        misalign_fault;
  logic [31:0] fetch_count;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  logic csPrev      = 1'b0;
  exp_t expQ[$];

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_cs         (rom_cs),
    .rom_data       (rom_data),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .ir_data        (ir_data),
    .ir_pc          (ir_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_fault (misalign_fault),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] romWord(input logic [31:0] a);
    case (a)
      32'h0000_016c: return 32'h0000_0093;
      32'h0000_0170: return 32'h0000_0113;
      32'h0000_0174: return 32'h0000_0193;
      default:       return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // ROM loads its output register on the rising edge of its strobe
  always @(posedge rom_cs) rom_data <= romWord(rom_addr);

  // The strobe must never be seen high on two consecutive clock edges
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      csPrev <= 1'b0;
    end else begin
      assert (!(csPrev && rom_cs)) else begin
        miscompares++;
        $error("[TB] FAIL rom_cs_consecutive: observed high twice, required at most once");
      end
      csPrev <= rom_cs;
    end
  end

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic pushExpected(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.data = romWord(pc);
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    ir_ready       = rdy;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, ir_ready);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expQ.delete();
  endtask

  // Waits (bounded) for ir_valid at a negedge, then compares against the queue head
  task automatic checkOutput(input string tag, output int validCyc);
    exp_t e;
    int   n;
    n = 0;
    validCyc = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!ir_valid && n < 20);
    if (!ir_valid) begin
      checkValue({tag, "_timeout"}, {31'h0, ir_valid}, 32'h1);
    end else if (expQ.size() == 0) begin
      checkValue({tag, "_unexpected"}, ir_pc, 32'hFFFF_FFFF);
    end else begin
      e = expQ.pop_front();
      validCyc = cyc;
      checkValue({tag, "_pc"}, ir_pc, e.pc);
      checkValue({tag, "_data"}, ir_data, e.data);
    end
  endtask

  task automatic waitStrobe(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rom_cs && n < 10);
    if (!rom_cs) checkValue({tag, "_strobe_timeout"}, 32'h0, 32'h1);
  endtask

  initial begin
    int t0, t1, vc;

    // Reset state, then three sequential fetches at full rate
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkValue("rst_rom_cs", {31'h0, rom_cs}, 32'h0);
    checkValue("rst_rom_addr", rom_addr, 32'h0000_016c);
    checkValue("rst_ir_valid", {31'h0, ir_valid}, 32'h0);
    checkValue("rst_ir_data", ir_data, 32'h0);
    checkValue("rst_ir_pc", ir_pc, 32'h0);
    checkValue("rst_fault", {31'h0, misalign_fault}, 32'h0);
    checkValue("rst_count", fetch_count, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyReset();
    pushExpected(32'h0000_016c);
    pushExpected(32'h0000_0170);
    pushExpected(32'h0000_0174);
    checkOutput("seq0", t0);
    checkOutput("seq1", t1);
    checkValue("seq_gap01", t1 - t0, 32'd3);
    checkOutput("seq2", vc);
    checkValue("seq_gap12", vc - t1, 32'd3);
    @(negedge clk);
    checkValue("seq_count", fetch_count, 32'd3);

    // Backpressure: word held stable, no strobe, then continues at 0x170
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyReset();
    pushExpected(32'h0000_016c);
    checkOutput("hold0", vc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkValue("hold_valid", {31'h0, ir_valid}, 32'h1);
      checkValue("hold_pc", ir_pc, 32'h0000_016c);
      checkValue("hold_data", ir_data, 32'h0000_0093);
      checkValue("hold_cs", {31'h0, rom_cs}, 32'h0);
    end
    ir_ready = 1'b1;
    pushExpected(32'h0000_0170);
    checkOutput("hold1", vc);

    // Redirect during STROBE drops the captured word
    waitStrobe("redir_strobe");
    applyStimulus(1'b1, 32'h0000_0444, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkValue("redir_valid", {31'h0, ir_valid}, 32'h0);
    checkValue("redir_count", fetch_count, 32'd2);
    pushExpected(32'h0000_0444);
    checkOutput("redir", vc);
    @(negedge clk);
    checkValue("redir_count_after", fetch_count, 32'd3);

    // Redirect and ready in the same HOLD cycle: redirect wins
    ir_ready = 1'b0;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!ir_valid && n < 20);
      checkValue("both_wait_valid", {31'h0, ir_valid}, 32'h1);
    end
    applyStimulus(1'b1, 32'h0000_0800, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkValue("both_valid", {31'h0, ir_valid}, 32'h0);
    checkValue("both_count", fetch_count, 32'd3);
    pushExpected(32'h0000_0800);
    checkOutput("both", vc);

    // Misaligned redirect: sticky fault, fetch from aligned address
    applyStimulus(1'b1, 32'h0000_0446, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkValue("mis_fault", {31'h0, misalign_fault}, 32'h1);
    checkValue("mis_addr", rom_addr, 32'h0000_0444);
    checkValue("mis_count", fetch_count, 32'd3);
    pushExpected(32'h0000_0444);
    checkOutput("mis", vc);
    @(negedge clk);
    checkValue("mis_count_after", fetch_count, 32'd4);
    checkValue("mis_fault_sticky", {31'h0, misalign_fault}, 32'h1);

    // PC wraps modulo 2^32
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1);
    pushExpected(32'hFFFF_FFFC);
    pushExpected(32'h0000_0000);
    checkOutput("wrap0", vc);
    checkOutput("wrap1", vc);
    @(negedge clk);
    checkValue("wrap_count", fetch_count, 32'd6);
    checkValue("wrap_fault_sticky", {31'h0, misalign_fault}, 32'h1);

    // Async reset in STROBE: outputs drop without a clock edge
    waitStrobe("arst");
    #2 rst = 1'b1;
    #1;
    checkValue("arst_cs", {31'h0, rom_cs}, 32'h0);
    checkValue("arst_valid", {31'h0, ir_valid}, 32'h0);
    checkValue("arst_fault", {31'h0, misalign_fault}, 32'h0);
    checkValue("arst_addr", rom_addr, 32'h0000_016c);
    @(negedge clk);
    rst = 1'b0;
    expQ.delete();
    @(negedge clk);
    checkValue("arst_no_early_cs", {31'h0, rom_cs}, 32'h0);
    pushExpected(32'h0000_016c);
    checkOutput("arst", vc);
    checkValue("arst_queue_empty", expQ.size(), 32'd0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
